// File: rtl/max_unpool_pkg.sv
// Shared CNN definitions: history codes, unpool FSM states, default data width.
package max_unpool_pkg;

    localparam int DW_DEF = 16;

    // argmax position inside a 2x2 window, as (row,col) offsets
    localparam logic [2:0] HIST_TL = 3'd0;
    localparam logic [2:0] HIST_TR = 3'd1;
    localparam logic [2:0] HIST_BL = 3'd2;
    localparam logic [2:0] HIST_BR = 3'd3;

    typedef enum logic [1:0] {LOAD, EMIT, DONE} state_t;

    // history code that selects the window position (r0,c0)
    function automatic logic [2:0] win_pos(input logic r0, input logic c0);
        case ({r0, c0})
            2'b00:   win_pos = HIST_TL;
            2'b01:   win_pos = HIST_TR;
            2'b10:   win_pos = HIST_BL;
            default: win_pos = HIST_BR;
        endcase
    endfunction

endpackage

// File: rtl/max_unpool_buf.sv
// N x N buffer of {history, value} entries: one write port, one async read port.
module unpool_buf #(
    parameter int N  = 3,
    parameter int DW = 16,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_row,
    input  logic [AW-1:0] wr_col,
    input  logic [DW+2:0] wr_data,
    input  logic [AW-1:0] rd_row,
    input  logic [AW-1:0] rd_col,
    output logic [DW+2:0] rd_data
);

    logic [DW+2:0] mem [N][N];

    // contents are don't-care after reset, so no reset on the array
    always_ff @(posedge clk) begin
        if (we) mem[wr_row][wr_col] <= wr_data;
    end

    assign rd_data = mem[rd_row][rd_col];

endmodule

// File: rtl/max_unpool.sv
// Max-unpool: buffer an N x N pooled map with argmax codes, then stream the
// 2N x 2N reconstruction row-major with only the recorded position non-zero.
module max_unpool import max_unpool_pkg::*; #(
    parameter int N  = 3,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    output logic          in_ready,
    input  logic [DW-1:0] in,
    input  logic [2:0]    history,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] result,
    output logic [5:0]    out_row,
    output logic [5:0]    out_col,
    output logic          hist_err,
    output logic          done_up
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] IN_MAX  = AW'(N - 1);
    localparam logic [5:0]    OUT_MAX = 6'(2 * N - 1);

    state_t        state;
    logic [AW-1:0] ir, ic;
    logic          accept, last_beat, last_elem;
    logic [5:0]    nr, nc;
    logic [DW+2:0] rd_data;
    logic [DW-1:0] src_val, next_res;
    logic [2:0]    src_hist;

    assign accept    = load & in_ready;
    assign last_beat = accept && (ir == IN_MAX) && (ic == IN_MAX);
    assign last_elem = (out_row == OUT_MAX) && (out_col == OUT_MAX);

    unpool_buf #(.N(N), .DW(DW), .AW(AW)) u_buf (
        .clk     (clk),
        .we      (accept),
        .wr_row  (ir),
        .wr_col  (ic),
        .wr_data ({history, in}),
        .rd_row  (nr[AW:1]),
        .rd_col  (nc[AW:1]),
        .rd_data (rd_data)
    );

    // coordinates of the element to present next; (0,0) while loading
    always_comb begin
        nr = '0;
        nc = '0;
        if (state == EMIT) begin
            if (out_col == OUT_MAX) begin
                nr = out_row + 6'd1;
                nc = '0;
            end else begin
                nr = out_row;
                nc = out_col + 6'd1;
            end
        end
    end

    // value of the next element; with N=1 the only entry is still being written
    always_comb begin
        {src_hist, src_val} = rd_data;
        if (N == 1 && state == LOAD) {src_hist, src_val} = {history, in};
        next_res = (src_hist == win_pos(nr[0], nc[0])) ? src_val : '0;
    end

    // frame FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            ir        <= '0;
            ic        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            out_row   <= '0;
            out_col   <= '0;
            hist_err  <= 1'b0;
            done_up   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        // first beat of a frame restarts the sticky flag
                        if (ir == '0 && ic == '0) hist_err <= (history > HIST_BR);
                        else if (history > HIST_BR) hist_err <= 1'b1;
                        if (last_beat) begin
                            ir        <= '0;
                            ic        <= '0;
                            out_row   <= '0;
                            out_col   <= '0;
                            result    <= next_res;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= EMIT;
                        end else if (ic == IN_MAX) begin
                            ic <= '0;
                            ir <= ir + 1'b1;
                        end else begin
                            ic <= ic + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (last_elem) begin
                            out_valid <= 1'b0;
                            done_up   <= 1'b1;
                            state     <= DONE;
                        end else begin
                            out_row <= nr;
                            out_col <= nc;
                            result  <= next_res;
                        end
                    end
                end
                DONE: begin
                    done_up  <= 1'b0;
                    in_ready <= 1'b1;
                    out_row  <= '0;
                    out_col  <= '0;
                    result   <= '0;
                    state    <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
